// File: rtl/csd_recoder_if.sv
// Valid/ready bundle between a coefficient source, the CSD recoder and a digit consumer.
// master: recoder view (accepts coefficients, produces digit beats).
// slave : environment view (supplies coefficients, consumes digit beats).
interface csd_recoder_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned PW = $clog2(W),
    parameter int unsigned CW = $clog2(W + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  coef;
    logic                 out_valid;
    logic                 out_ready;
    logic                 dig_nz;
    logic                 dig_neg;
    logic [PW-1:0]        dig_pos;
    logic                 out_last;
    logic [CW-1:0]        nz_count;

    modport master (
        input  in_valid, coef, out_ready,
        output in_ready, out_valid, dig_nz, dig_neg, dig_pos, out_last, nz_count
    );

    modport slave (
        output in_valid, coef, out_ready,
        input  in_ready, out_valid, dig_nz, dig_neg, dig_pos, out_last, nz_count
    );
endinterface

// File: rtl/csd_recoder.sv
// Sequential canonical-signed-digit recoder: one W-bit coefficient in, CSD digits out LSB first.
// Optional build macro CSD_ZERO_SKIP_EN: emit only nonzero digits (a lone zero beat for coef 0).
module csd_recoder #(
    parameter int unsigned W  = 16,
    parameter int unsigned PW = $clog2(W),
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    csd_recoder_if.master bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [W-1:0]   sr;      // remaining coefficient bits, sr[0] is the bit of position pos
    logic           carry;
    logic [PW-1:0]  pos;
    logic           rdy_q;
    logic           ov_q;
    logic           nz_q;
    logic           neg_q;
    logic           last_q;
    logic [PW-1:0]  dpos_q;
    logic [CW-1:0]  cnt_q;

    logic [W-1:0]   src;
    logic           cin;
    logic           b_nz;
    logic           b_neg;
    logic           b_cout;
    logic [W-1:0]   nxt;
`ifdef CSD_ZERO_SKIP_EN
    logic           rem_zero;
`endif

    // Digit for the bit under examination: the incoming coef when idle, the shift register otherwise.
    always_comb begin
        src = sr;
        cin = carry;
        if (state == IDLE) begin
            src = bus.coef;
            cin = 1'b0;
        end
        b_nz   = src[0] ^ cin;
        b_neg  = b_nz & src[1];
        b_cout = (src[0] & cin) | b_neg;
        nxt    = {src[W-1], src[W-1:1]};
`ifdef CSD_ZERO_SKIP_EN
        // All higher digits are zero when the remaining value plus carry is 0 (or wraps to 0).
        rem_zero = ((nxt == '0) && !b_cout) || ((nxt == '1) && b_cout);
`endif
    end

    // in_ready is dropped for the reset cycle itself so nothing is accepted while rst is high.
    assign bus.in_ready  = rdy_q & ~rst;
    assign bus.out_valid = ov_q;
    assign bus.dig_nz    = nz_q;
    assign bus.dig_neg   = neg_q;
    assign bus.dig_pos   = dpos_q;
    assign bus.out_last  = last_q;
    assign bus.nz_count  = cnt_q;

    // Control FSM, recoding datapath and registered beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            carry  <= 1'b0;
            pos    <= '0;
            rdy_q  <= 1'b1;
            ov_q   <= 1'b0;
            nz_q   <= 1'b0;
            neg_q  <= 1'b0;
            last_q <= 1'b0;
            dpos_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state  <= RUN;
                        rdy_q  <= 1'b0;
                        sr     <= nxt;
                        carry  <= b_cout;
                        pos    <= PW'(1);
                        nz_q   <= b_nz;
                        neg_q  <= b_neg;
                        dpos_q <= '0;
                        cnt_q  <= CW'(b_nz);
`ifdef CSD_ZERO_SKIP_EN
                        ov_q   <= b_nz | rem_zero;
                        last_q <= rem_zero;
`else
                        ov_q   <= 1'b1;
                        last_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
`ifdef CSD_ZERO_SKIP_EN
                    if (ov_q) begin
                        if (bus.out_ready) begin
                            if (last_q) begin
                                state  <= IDLE;
                                rdy_q  <= 1'b1;
                                nz_q   <= 1'b0;
                                neg_q  <= 1'b0;
                                dpos_q <= '0;
                                cnt_q  <= '0;
                                last_q <= 1'b0;
                            end
                            ov_q <= 1'b0;
                        end
                    end else begin
                        sr    <= nxt;
                        carry <= b_cout;
                        pos   <= pos + PW'(1);
                        if (b_nz) begin
                            ov_q   <= 1'b1;
                            nz_q   <= 1'b1;
                            neg_q  <= b_neg;
                            dpos_q <= pos;
                            last_q <= rem_zero;
                            cnt_q  <= cnt_q + CW'(1);
                        end
                    end
`else
                    if (bus.out_ready) begin
                        if (last_q) begin
                            state  <= IDLE;
                            rdy_q  <= 1'b1;
                            ov_q   <= 1'b0;
                            nz_q   <= 1'b0;
                            neg_q  <= 1'b0;
                            dpos_q <= '0;
                            cnt_q  <= '0;
                            last_q <= 1'b0;
                        end else begin
                            sr     <= nxt;
                            carry  <= b_cout;
                            pos    <= pos + PW'(1);
                            nz_q   <= b_nz;
                            neg_q  <= b_neg;
                            dpos_q <= pos;
                            last_q <= (pos == PW'(W - 1));
                            cnt_q  <= cnt_q + CW'(b_nz);
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csd_recoder.sv
// Scoreboard bench for csd_recoder: a NAF reference model queues expected beats per coefficient.
module tb_csd_recoder;
    localparam int unsigned W  = 16;
    localparam int unsigned PW = $clog2(W);
    localparam int unsigned CW = $clog2(W + 1);

    typedef struct {
        logic nz;
        logic neg;
        int   pos;
        logic last;
        int   cnt;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    csd_recoder_if #(.W(W), .PW(PW), .CW(CW)) bus ();

    csd_recoder #(.W(W), .PW(PW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    last_hs_cyc = -10;
    int    seen     = 0;
    bit    bp_en    = 1'b0;
    beat_t exp_q[$];
    int    coef_q[$];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: random or constant out_ready, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops expected beats on each handshake, checks stalls, sums and adjacency.
    longint sum = 0;
    bit     adj = 1'b0;
    int     prev_nz_pos = -2;
    bit     stalled = 1'b0;
    logic   s_nz, s_neg, s_last;
    int     s_pos, s_cnt;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            exp_q.delete();
            coef_q.delete();
            sum = 0;
            adj = 1'b0;
            prev_nz_pos = -2;
            stalled = 1'b0;
            seen = 0;
        end else begin
            if (stalled) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_beat", {bus.dig_nz, bus.dig_neg, bus.out_last, int'(bus.dig_pos), int'(bus.nz_count)},
                      {s_nz, s_neg, s_last, s_pos, s_cnt});
            end
            stalled = 1'b0;
            if (bus.out_valid) begin
                check("busy_in_ready", bus.in_ready, 0);
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dig_nz", bus.dig_nz, e.nz);
                        check("dig_neg", bus.dig_neg, e.neg);
                        check("dig_pos", bus.dig_pos, e.pos);
                        check("out_last", bus.out_last, e.last);
                        check("nz_count", bus.nz_count, e.cnt);
                    end
                    if (bus.dig_nz) begin
                        if (prev_nz_pos == int'(bus.dig_pos) - 1) adj = 1'b1;
                        prev_nz_pos = int'(bus.dig_pos);
                        sum += (bus.dig_neg ? -64'sd1 : 64'sd1) <<< bus.dig_pos;
                    end
                    seen++;
                    if (bus.out_last) begin
                        if (coef_q.size() != 0) check("sum", sum, coef_q.pop_front());
                        else check("sum_no_coef", 1, 0);
                        check("adjacent_nz", adj, 0);
                        sum = 0;
                        adj = 1'b0;
                        prev_nz_pos = -2;
                        seen = 0;
                        last_hs_cyc = cyc;
                    end
                end else begin
                    stalled = 1'b1;
                    s_nz  = bus.dig_nz;
                    s_neg = bus.dig_neg;
                    s_last = bus.out_last;
                    s_pos = int'(bus.dig_pos);
                    s_cnt = int'(bus.nz_count);
                end
            end
        end
    end

    // Reference: non-adjacent form by repeated odd/even reduction, queued as expected beats.
    task automatic push_model(input int c);
        int   x;
        int   d [W];
        int   cnt;
        int   top;
        beat_t b;
        x = c;
        top = -1;
        for (int p = 0; p < W; p++) begin
            d[p] = ((x & 1) != 0) ? (2 - (x & 3)) : 0;
            x = (x - d[p]) >>> 1;
            if (d[p] != 0) top = p;
        end
        cnt = 0;
        for (int p = 0; p < W; p++) begin
            cnt += (d[p] != 0) ? 1 : 0;
            b.nz = (d[p] != 0);
            b.neg = (d[p] < 0);
            b.pos = p;
            b.cnt = cnt;
`ifdef CSD_ZERO_SKIP_EN
            b.last = (p == top);
            if (b.nz) exp_q.push_back(b);
`else
            b.last = (p == W - 1);
            exp_q.push_back(b);
`endif
        end
`ifdef CSD_ZERO_SKIP_EN
        if (top < 0) begin
            b.nz = 1'b0; b.neg = 1'b0; b.pos = 0; b.last = 1'b1; b.cnt = 0;
            exp_q.push_back(b);
        end
`endif
        coef_q.push_back(c);
    endtask

    // Offer a coefficient, wait for acceptance, then check first-beat latency.
    task automatic send(input int c, input bit chk_b2b);
        bit ok;
        bit first_pos0;
        int n0;
        @(posedge clk);
        #1;
        bus.coef = 16'(c);
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        check("accept_timeout", ok, 1);
        if (chk_b2b) check("b2b_accept_cycle", cyc, last_hs_cyc + 1);
        n0 = exp_q.size();
        push_model(c);
        first_pos0 = (exp_q[n0].pos == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        if (first_pos0) check("first_beat_latency", bus.out_valid, 1);
        check("in_ready_after_accept", bus.in_ready, 0);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && bus.in_ready) begin ok = 1'b1; break; end
        end
        check("done_timeout", ok, 1);
    endtask

    initial begin
        bit ok;
        bus.in_valid = 1'b0;
        bus.coef = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_beat", {bus.dig_nz, bus.dig_neg, bus.out_last, int'(bus.dig_pos), int'(bus.nz_count)}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_out_valid", bus.out_valid, 0);

        send(-355, 1'b0);   wait_done();
        send(32767, 1'b0);  wait_done();
        send(-32768, 1'b0); wait_done();
        send(0, 1'b0);      wait_done();

        bp_en = 1'b1;
        send(23333, 1'b0);  wait_done();
        for (int k = 0; k < 12; k++) begin
            send(int'($signed(16'($urandom))), 1'b0);
            wait_done();
        end
        bp_en = 1'b0;
        @(posedge clk);

        // Abort a coefficient on its 4th beat and confirm a clean restart.
        send(-23333, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (seen == 4) begin ok = 1'b1; break; end
        end
        check("abort_timeout", ok, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        send(5, 1'b0);      wait_done();

        // Back-to-back: 1000 held on the bus during the previous coefficient's last beat.
        send(200, 1'b0);
        send(1000, 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/csd_recoder.md
Name: csd_recoder

Overview:
- Sequential canonical-signed-digit (CSD) recoder: takes a W-bit two's-complement coefficient and emits its CSD digits one per beat, LSB first.
- Digit stream drives shift-add constant-multiplier generation and checking (CSD/CSA multiplier family), i.e. the producer side of the digits those multipliers consume.
- Valid/ready on both sides; one coefficient in flight at a time.

Parameters:
- W, 16, coefficient width in bits; also the number of CSD digit positions (0..W-1).
- PW, $clog2(W), width of digit position field.
- CW, $clog2(W+1), width of nonzero-digit counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  coefficient valid.
- in_ready  out  1  recoder can accept a coefficient.
- coef  in  W  signed two's-complement coefficient.
- out_valid  out  1  digit beat valid.
- out_ready  in  1  consumer accepts beat.
- dig_nz  out  1  digit is nonzero.
- dig_neg  out  1  digit is -1 (meaningful only when dig_nz=1; 0 otherwise).
- dig_pos  out  PW  digit weight exponent (digit value x 2^dig_pos).
- out_last  out  1  final beat of this coefficient.
- nz_count  out  CW  nonzero digits in beats up to and including current beat.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1 (IDLE). out_valid=0, dig_nz=0, dig_neg=0, dig_pos=0, out_last=0, nz_count=0. Internal carry=0.
- Reset mid-operation: coefficient discarded, FSM to IDLE, no further beats.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch coef into shift register, carry=0, pos=0, count=0, go to RUN.
  - RUN: in_ready=0, out_valid=1. On out_valid&&out_ready, advance to the next digit. After the out_last handshake, return to IDLE.
- Latency: coef accepted in cycle N gives first beat valid in cycle N+1. With out_ready held high, one beat per cycle; W beats total (non-skip mode). Next coef accepted no earlier than the cycle after the out_last handshake.
- All beat outputs derive from registered state only and are held stable while out_valid&&!out_ready. No combinational path from out_ready or in_valid to any output.
- Recoding rule, bit i, with b_W = b_{W-1} (sign extension); s = b_i + carry:
  - s=0: digit 0, carry 0.
  - s=2: digit 0, carry 1.
  - s=1 and b_{i+1}=0: digit +1, carry 0.
  - s=1 and b_{i+1}=1: digit -1, carry 1.
  - Carry out of position W-1 is discarded; the result is exact for all W-bit inputs, including -2^(W-1) and 2^(W-1)-1.
- Invariants: no two adjacent nonzero digits; sum of digit x 2^pos == coef.
- nz_count increments by dig_nz per beat. On the out_last beat it equals the total nonzero digit count (max ceil(W/2)+... bounded by CW bits). Cleared on accept.
- in_valid while in RUN is ignored (in_ready=0). Upstream holds coef until accepted.

Optional Feature:
- Macro: CSD_ZERO_SKIP_EN.
- Defined: only nonzero digits are emitted. Recoder scans internally one bit per cycle and presents a beat only when the digit is nonzero. out_last is set on the highest nonzero digit. Coefficient 0 emits exactly one beat: dig_nz=0, dig_pos=0, out_last=1, nz_count=0.
- Undefined: all W digits emitted; dig_pos = 0..W-1 in order; out_last on pos W-1.

Test Plan:
- Reset, then coef=-355 (0xFE9D), out_ready=1: 16 beats; nonzero at pos0 +1, pos2 -1, pos5 +1, pos7 +1, pos9 -1; last beat nz_count=5. Skip mode: exactly those 5 beats, last at pos9.
- coef=32767: pos0 -1, pos15 +1, others zero, nz_count=2. coef=-32768: single nonzero at pos15 -1, nz_count=1.
- coef=0: all digits zero, nz_count=0. Skip mode: single beat, dig_nz=0, out_last=1.
- Backpressure: coef=23333, out_ready toggled randomly. Outputs stable while stalled; reconstructed sum = 23333; no adjacent nonzero digits; in_ready=0 until after out_last handshake.
- rst asserted on the 4th beat of coef=-23333: next cycle out_valid=0, in_ready=1; following coef=5 yields pos0 +1, pos2 +1, nz_count=2 with no residue from the aborted coefficient.
- Back-to-back: 1000 offered with in_valid held during the previous coefficient's last beat. Accepted the cycle after the out_last handshake; first beat one cycle later; sum = 1000.
